// File: rtl/pipe_kogge_stone_sub_nbit.sv
// Two-stage pipelined Kogge-Stone subtractor with valid/ready flow control.
//
// Computes diff = A - B - bin as A + ~B + ~bin. The lower half is resolved in
// stage 1 and the carry out of it is registered; the upper half is resolved in
// stage 2 from the registered upper operand slices. The output register carries
// the result and the borrow, overflow and zero flags.
//
// Ports:
//   CLK        clock, rising edge
//   RESETn     asynchronous active-low reset
//   in_valid   operands presented
//   in_ready   block accepts operands this cycle
//   A, B       minuend, subtrahend [bw:1]
//   bin        borrow in
//   out_valid  output registers hold a valid result
//   out_ready  downstream accepts the result
//   diff       A - B - bin mod 2^bw
//   bout       1 when unsigned A < B + bin
//   ovf        two's-complement overflow
//   zero       diff == 0
module pipe_kogge_stone_sub_nbit #(
    parameter int bw = 32
) (
    input  logic          CLK,
    input  logic          RESETn,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [bw:1]   A,
    input  logic [bw:1]   B,
    input  logic          bin,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [bw:1]   diff,
    output logic          bout,
    output logic          ovf,
    output logic          zero
);

    localparam int hbw = bw / 2;

    // Kogge-Stone adder over hbw bits: black cells combine (g, p) pairs at
    // doubling distances; bits below the distance pass through as buffers.
    // The carry in is folded in at the end: c[i] = G[i-1:0] | P[i-1:0] & cin.
    // Returns {carry_out, sum}.
    function automatic logic [hbw:0] ks_add(input logic [hbw-1:0] a,
                                            input logic [hbw-1:0] b,
                                            input logic           cin);
        logic [hbw-1:0] g;
        logic [hbw-1:0] p;
        logic [hbw-1:0] gg;
        logic [hbw-1:0] pp;
        logic [hbw-1:0] gn;
        logic [hbw-1:0] pn;
        logic [hbw-1:0] c;
        g  = a & b;
        p  = a ^ b;
        gg = g;
        pp = p;
        for (int d = 1; d < hbw; d = d * 2) begin
            gn = gg;
            pn = pp;
            for (int i = d; i < hbw; i++) begin
                gn[i] = gg[i] | (pp[i] & gg[i-d]);
                pn[i] = pp[i] & pp[i-d];
            end
            gg = gn;
            pp = pn;
        end
        c[0] = cin;
        for (int i = 1; i < hbw; i++) begin
            c[i] = gg[i-1] | (pp[i-1] & cin);
        end
        return {gg[hbw-1] | (pp[hbw-1] & cin), p ^ c};
    endfunction

    // Stage 1 registers
    logic           s1_valid_q, s1_valid_d;
    logic [hbw-1:0] s1_dlo_q;
    logic           s1_ch_q;
    logic [hbw-1:0] s1_ahi_q;
    logic [hbw-1:0] s1_nbhi_q;
    logic           s1_asign_q;
    logic           s1_bsign_q;

    // Output registers
    logic           out_valid_q, out_valid_d;
    logic [bw:1]    diff_q;
    logic           bout_q;
    logic           ovf_q;
    logic           zero_q;

    // Handshake
    logic s2_load;
    logic in_xfer;
    logic out_xfer;

    // Datapath
    logic [hbw:0]   lo_res;
    logic [hbw:0]   hi_res;
    logic [bw:1]    diff_next;

    always_comb begin
        s2_load  = s1_valid_q && (!out_valid_q || out_ready);
        in_ready = !s1_valid_q || s2_load;
        in_xfer  = in_valid && in_ready;
        out_xfer = out_valid_q && out_ready;

        s1_valid_d = s1_valid_q;
        if (in_xfer) begin
            s1_valid_d = 1'b1;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end

        out_valid_d = out_valid_q;
        if (s2_load) begin
            out_valid_d = 1'b1;
        end else if (out_xfer) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        lo_res    = ks_add(A[hbw:1], ~B[hbw:1], ~bin);
        hi_res    = ks_add(s1_ahi_q, s1_nbhi_q, s1_ch_q);
        diff_next = {hi_res[hbw-1:0], s1_dlo_q};
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            s1_valid_q  <= 1'b0;
            s1_dlo_q    <= '0;
            s1_ch_q     <= 1'b0;
            s1_ahi_q    <= '0;
            s1_nbhi_q   <= '0;
            s1_asign_q  <= 1'b0;
            s1_bsign_q  <= 1'b0;
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            if (in_xfer) begin
                s1_dlo_q   <= lo_res[hbw-1:0];
                s1_ch_q    <= lo_res[hbw];
                s1_ahi_q   <= A[bw:hbw+1];
                s1_nbhi_q  <= ~B[bw:hbw+1];
                s1_asign_q <= A[bw];
                s1_bsign_q <= B[bw];
            end
            if (s2_load) begin
                diff_q <= diff_next;
                bout_q <= ~hi_res[hbw];
                // Overflow only when operand signs differ and the result sign
                // departs from the minuend's.
                ovf_q  <= (s1_asign_q != s1_bsign_q) && (diff_next[bw] != s1_asign_q);
                zero_q <= ~|diff_next;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule
